// File: rtl/coram_channel_thread_end_if.sv
// rtl/coram_channel_thread_end_if.sv - user/thread channel signal bundle; err_clr/err present under CORAM_CHANNEL_ERR_EN
interface coram_channel_thread_end_if #(
  parameter int WIDTH    = 64,
  parameter int LOGDEPTH = 4
);
  logic [WIDTH-1:0]  dout;
  logic              dout_en;
  logic              dout_rdy;
  logic [WIDTH-1:0]  din;
  logic              din_en;
  logic              din_rdy;
  logic [WIDTH-1:0]  t_rdata;
  logic              t_rvalid;
  logic              t_rready;
  logic [WIDTH-1:0]  t_wdata;
  logic              t_wvalid;
  logic              t_wready;
  logic [LOGDEPTH:0] u2t_count;
  logic [LOGDEPTH:0] t2u_count;
  logic [31:0]       thread_id_o;
  logic [31:0]       chan_id_o;
`ifdef CORAM_CHANNEL_ERR_EN
  logic              err_clr;
  logic [3:0]        err;
`endif

  modport slave (
    input  dout, dout_en, din_en, t_rready, t_wdata, t_wvalid,
`ifdef CORAM_CHANNEL_ERR_EN
    input  err_clr,
    output err,
`endif
    output dout_rdy, din, din_rdy, t_rdata, t_rvalid, t_wready,
    output u2t_count, t2u_count, thread_id_o, chan_id_o
  );

  modport master (
    output dout, dout_en, din_en, t_rready, t_wdata, t_wvalid,
`ifdef CORAM_CHANNEL_ERR_EN
    output err_clr,
    input  err,
`endif
    input  dout_rdy, din, din_rdy, t_rdata, t_rvalid, t_wready,
    input  u2t_count, t2u_count, thread_id_o, chan_id_o
  );
endinterface

// File: rtl/coram_channel_thread_end.sv
// rtl/coram_channel_thread_end.sv - CoRAM channel thread endpoint: u2t and t2u FWFT FIFOs; sticky error flags under CORAM_CHANNEL_ERR_EN
module coram_channel_thread_end #(
  parameter int WIDTH           = 64,
  parameter int DEPTH           = 16,
  parameter int LOGDEPTH        = 4,
  parameter int CORAM_THREAD_ID = 0,
  parameter int CORAM_ID        = 0
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  coram_channel_thread_end_if.slave ch
);

  localparam logic [LOGDEPTH:0]   FULL_CNT = (LOGDEPTH+1)'(DEPTH);
  localparam logic [LOGDEPTH:0]   CNT_ONE  = (LOGDEPTH+1)'(1);
  localparam logic [LOGDEPTH-1:0] PTR_ONE  = LOGDEPTH'(1);

  logic [WIDTH-1:0]    mem_u2t [DEPTH];
  logic [LOGDEPTH-1:0] u2t_wr_ptr;
  logic [LOGDEPTH-1:0] u2t_rd_ptr;
  logic [LOGDEPTH:0]   u2t_cnt;

  logic [WIDTH-1:0]    mem_t2u [DEPTH];
  logic [LOGDEPTH-1:0] t2u_wr_ptr;
  logic [LOGDEPTH-1:0] t2u_rd_ptr;
  logic [LOGDEPTH:0]   t2u_cnt;

  logic u2t_not_full;
  logic u2t_not_empty;
  logic t2u_not_full;
  logic t2u_not_empty;
  logic push_u2t;
  logic pop_u2t;
  logic push_t2u;
  logic pop_t2u;

  // Flags depend only on registered counts, so a same-cycle pop never frees a slot.
  assign u2t_not_full  = (u2t_cnt != FULL_CNT);
  assign u2t_not_empty = (u2t_cnt != '0);
  assign t2u_not_full  = (t2u_cnt != FULL_CNT);
  assign t2u_not_empty = (t2u_cnt != '0);

  assign push_u2t = ch.dout_en  & u2t_not_full;
  assign pop_u2t  = ch.t_rready & u2t_not_empty;
  assign push_t2u = ch.t_wvalid & t2u_not_full;
  assign pop_t2u  = ch.din_en   & t2u_not_empty;

  assign ch.dout_rdy  = u2t_not_full;
  assign ch.t_rvalid  = u2t_not_empty;
  assign ch.t_wready  = t2u_not_full;
  assign ch.din_rdy   = t2u_not_empty;
  assign ch.u2t_count = u2t_cnt;
  assign ch.t2u_count = t2u_cnt;

  assign ch.t_rdata = u2t_not_empty ? mem_u2t[u2t_rd_ptr] : '0;
  assign ch.din     = t2u_not_empty ? mem_t2u[t2u_rd_ptr] : '0;

  assign ch.thread_id_o = 32'(CORAM_THREAD_ID);
  assign ch.chan_id_o   = 32'(CORAM_ID);

  always_ff @(posedge CLK) begin
    if (push_u2t) mem_u2t[u2t_wr_ptr] <= ch.dout;
    if (push_t2u) mem_t2u[t2u_wr_ptr] <= ch.t_wdata;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      u2t_wr_ptr <= '0;
      u2t_rd_ptr <= '0;
      u2t_cnt    <= '0;
    end else begin
      if (push_u2t) u2t_wr_ptr <= u2t_wr_ptr + PTR_ONE;
      if (pop_u2t)  u2t_rd_ptr <= u2t_rd_ptr + PTR_ONE;
      case ({push_u2t, pop_u2t})
        2'b10:   u2t_cnt <= u2t_cnt + CNT_ONE;
        2'b01:   u2t_cnt <= u2t_cnt - CNT_ONE;
        default: u2t_cnt <= u2t_cnt;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      t2u_wr_ptr <= '0;
      t2u_rd_ptr <= '0;
      t2u_cnt    <= '0;
    end else begin
      if (push_t2u) t2u_wr_ptr <= t2u_wr_ptr + PTR_ONE;
      if (pop_t2u)  t2u_rd_ptr <= t2u_rd_ptr + PTR_ONE;
      case ({push_t2u, pop_t2u})
        2'b10:   t2u_cnt <= t2u_cnt + CNT_ONE;
        2'b01:   t2u_cnt <= t2u_cnt - CNT_ONE;
        default: t2u_cnt <= t2u_cnt;
      endcase
    end
  end

`ifdef CORAM_CHANNEL_ERR_EN
  logic [3:0] err_q;
  logic [3:0] err_evt;

  assign err_evt = {ch.t_rready & ~u2t_not_empty,
                    ch.t_wvalid & ~t2u_not_full,
                    ch.din_en   & ~t2u_not_empty,
                    ch.dout_en  & ~u2t_not_full};

  // New events are OR-ed after the clear so a same-cycle event survives err_clr.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) err_q <= '0;
    else        err_q <= (ch.err_clr ? 4'b0000 : err_q) | err_evt;
  end

  assign ch.err = err_q;
`endif

endmodule

// File: tb/tb_coram_channel_thread_end.sv
// tb/tb_coram_channel_thread_end.sv - directed bench for coram_channel_thread_end
module tb_coram_channel_thread_end;

  localparam int WIDTH = 64;
  localparam int LOGDEPTH = 4;
  localparam int DEPTH = 16;
  localparam int TID = 3;
  localparam int CID = 7;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 CLK = ~CLK;

  coram_channel_thread_end_if #(.WIDTH(WIDTH), .LOGDEPTH(LOGDEPTH)) ch ();

  coram_channel_thread_end #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .LOGDEPTH(LOGDEPTH),
    .CORAM_THREAD_ID(TID), .CORAM_ID(CID)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .ch(ch)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " dout_rdy"}, 64'(ch.dout_rdy), 64'd1);
    check({tag, " t_wready"}, 64'(ch.t_wready), 64'd1);
    check({tag, " din_rdy"}, 64'(ch.din_rdy), 64'd0);
    check({tag, " t_rvalid"}, 64'(ch.t_rvalid), 64'd0);
    check({tag, " din"}, ch.din, 64'd0);
    check({tag, " t_rdata"}, ch.t_rdata, 64'd0);
    check({tag, " u2t_count"}, 64'(ch.u2t_count), 64'd0);
    check({tag, " t2u_count"}, 64'(ch.t2u_count), 64'd0);
  endtask

  initial begin
    ch.dout = '0; ch.dout_en = 0; ch.din_en = 0;
    ch.t_rready = 0; ch.t_wdata = '0; ch.t_wvalid = 0;
`ifdef CORAM_CHANNEL_ERR_EN
    ch.err_clr = 0;
`endif
    tick(); tick();
    check_reset_outputs("rst");
    check("thread_id", 64'(ch.thread_id_o), 64'(TID));
    check("chan_id", 64'(ch.chan_id_o), 64'(CID));
`ifdef CORAM_CHANNEL_ERR_EN
    check("rst err", 64'(ch.err), 64'd0);
`endif
    RST_N = 1;
    tick();

    // user pushes three words, thread drains them
    for (int i = 0; i < 3; i++) begin
      ch.dout = 64'h11 * 64'(i + 1); ch.dout_en = 1;
      if (i == 0) check("no comb push path", 64'(ch.t_rvalid), 64'd0);
      tick();
    end
    ch.dout_en = 0;
    check("u2t count3", 64'(ch.u2t_count), 64'd3);
    check("t_rvalid3", 64'(ch.t_rvalid), 64'd1);
    check("t_rdata head", ch.t_rdata, 64'h11);
    ch.t_rready = 1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("u2t order %0d", i), ch.t_rdata, 64'h11 * 64'(i + 1));
      tick();
    end
    ch.t_rready = 0;
    check("u2t drained cnt", 64'(ch.u2t_count), 64'd0);
    check("u2t drained valid", 64'(ch.t_rvalid), 64'd0);
    check("u2t drained data", ch.t_rdata, 64'd0);

    // thread fills t2u, overflow word is dropped
    ch.t_wvalid = 1;
    for (int i = 0; i < 16; i++) begin
      ch.t_wdata = 64'h100 + 64'(i);
      tick();
    end
    check("t2u full wready", 64'(ch.t_wready), 64'd0);
    check("t2u full cnt", 64'(ch.t2u_count), 64'd16);
    ch.t_wdata = 64'h200;
    tick();
    ch.t_wvalid = 0;
    check("t2u drop cnt", 64'(ch.t2u_count), 64'd16);
    ch.din_en = 1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t2u order %0d", i), ch.din, 64'h100 + 64'(i));
      tick();
    end
    ch.din_en = 0;
    check("t2u empty rdy", 64'(ch.din_rdy), 64'd0);
    check("t2u empty din", ch.din, 64'd0);
    check("t2u empty cnt", 64'(ch.t2u_count), 64'd0);

    // steady-state push+pop at count 5, pointers wrap
    ch.t_wvalid = 1;
    for (int i = 0; i < 5; i++) begin
      ch.t_wdata = 64'h300 + 64'(i);
      tick();
    end
    ch.din_en = 1;
    for (int i = 0; i < 20; i++) begin
      ch.t_wdata = 64'h305 + 64'(i);
      check($sformatf("pp data %0d", i), ch.din, 64'h300 + 64'(i));
      tick();
      if (i == 19) check("pp count", 64'(ch.t2u_count), 64'd5);
    end
    ch.t_wvalid = 0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("pp tail %0d", i), ch.din, 64'h314 + 64'(i));
      tick();
    end
    ch.din_en = 0;
    check("pp final cnt", 64'(ch.t2u_count), 64'd0);

    // full u2t: pop accepted, simultaneous push refused
    ch.dout_en = 1;
    for (int i = 0; i < 16; i++) begin
      ch.dout = 64'h400 + 64'(i);
      tick();
    end
    check("u2t full rdy", 64'(ch.dout_rdy), 64'd0);
    ch.dout = 64'h4FF; ch.t_rready = 1;
    check("full pop head", ch.t_rdata, 64'h400);
    tick();
    ch.dout_en = 0;
    check("full pop cnt", 64'(ch.u2t_count), 64'd15);
    for (int i = 1; i < 16; i++) begin
      check($sformatf("full drain %0d", i), ch.t_rdata, 64'h400 + 64'(i));
      tick();
    end
    ch.t_rready = 0;
    check("full drain cnt", 64'(ch.u2t_count), 64'd0);

    // async reset mid-burst with u2t=7, t2u=3
    ch.dout_en = 1; ch.t_wvalid = 1;
    for (int i = 0; i < 7; i++) begin
      ch.dout = 64'h500 + 64'(i); ch.t_wdata = 64'h600 + 64'(i);
      if (i == 3) ch.t_wvalid = 0;
      tick();
    end
    check("pre-rst u2t", 64'(ch.u2t_count), 64'd7);
    check("pre-rst t2u", 64'(ch.t2u_count), 64'd3);
    #2 RST_N = 0;
    #1;
    check_reset_outputs("async rst");
    ch.dout_en = 0;
    tick();
    RST_N = 1;
    ch.dout = 64'h55; ch.dout_en = 1;
    tick();
    ch.dout_en = 0;
    check("post-rst data", ch.t_rdata, 64'h55);
    check("post-rst cnt", 64'(ch.u2t_count), 64'd1);
    ch.t_rready = 1;
    tick();
    ch.t_rready = 0;

`ifdef CORAM_CHANNEL_ERR_EN
    ch.din_en = 1;
    tick();
    ch.din_en = 0;
    check("err din_en empty", 64'(ch.err), 64'b0010);
    ch.err_clr = 1;
    tick();
    ch.err_clr = 0;
    check("err clr", 64'(ch.err), 64'd0);
    ch.t_wvalid = 1;
    for (int i = 0; i < 16; i++) begin
      ch.t_wdata = 64'(i);
      tick();
    end
    check("err full no flag", 64'(ch.err), 64'd0);
    ch.err_clr = 1;
    tick();
    ch.err_clr = 0; ch.t_wvalid = 0;
    check("err set beats clr", 64'(ch.err), 64'b0100);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
